// File: rtl/tcp_msg_poller_service_pkg.sv
// Shared types and sizing for the TCP message poller service side: stored
// request layout, FSM states, and the ctrl-to-datapath store-enable bundle.
package tcp_msg_poller_service_pkg;
  localparam int MAX_FLOW_CNT    = 256;
  localparam int FLOWID_W        = $clog2(MAX_FLOW_CNT);
  localparam int MSG_SRC_X_WIDTH = 8;
  localparam int MSG_SRC_Y_WIDTH = 8;
  localparam int NOC_FBITS_WIDTH = 4;
  localparam int MSG_LEN_W       = 32;

  typedef struct packed {
    logic [MSG_LEN_W-1:0]       length;
    logic [MSG_SRC_X_WIDTH-1:0] dst_x;
    logic [MSG_SRC_Y_WIDTH-1:0] dst_y;
    logic [NOC_FBITS_WIDTH-1:0] dst_fbits;
  } msg_req_mem_struct;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WAIT_RESP,
    ST_DECIDE,
    ST_NOTIF,
    ST_REQUEUE
  } svc_state_e;

  typedef struct packed {
    logic flowid_en;
    logic req_en;
    logic ptr_en;
  } store_en_t;
endpackage

// File: rtl/tcp_msg_poller_service_ctrl.sv
// Control FSM for the poller service: sequences pop, the two lookups, the
// decision and either notification or re-enqueue; drives datapath store enables.
module tcp_msg_poller_service_ctrl
  import tcp_msg_poller_service_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       q_empty_i,
  input  logic       q_wr_rdy_i,
  input  logic       mem_req_rdy_i,
  input  logic       mem_resp_val_i,
  input  logic       ptr_req_rdy_i,
  input  logic       ptr_resp_val_i,
  input  logic       notif_rdy_i,
  input  logic       data_ctrl_notify,
  output logic       pop_o,
  output logic       mem_req_val_o,
  output logic       ptr_req_val_o,
  output logic       mem_resp_rdy_o,
  output logic       ptr_resp_rdy_o,
  output logic       notif_val_o,
  output logic       requeue_val_o,
  output logic       clear_val_o,
  output store_en_t  store_en_o
);
  svc_state_e state_q;
  logic mem_req_done_q, ptr_req_done_q;
  logic mem_held_q, ptr_held_q;
  logic mem_req_fire, ptr_req_fire, mem_resp_fire, ptr_resp_fire;

  // Handshake outputs decode registered state only; pop and clear additionally
  // qualify on the partner's input so each is a one-cycle strobe.
  assign mem_req_val_o  = (state_q == ST_RD_REQ) && !mem_req_done_q;
  assign ptr_req_val_o  = (state_q == ST_RD_REQ) && !ptr_req_done_q;
  assign mem_resp_rdy_o = (state_q == ST_WAIT_RESP) && !mem_held_q;
  assign ptr_resp_rdy_o = (state_q == ST_WAIT_RESP) && !ptr_held_q;
  assign notif_val_o    = (state_q == ST_NOTIF);
  assign requeue_val_o  = (state_q == ST_REQUEUE);
  assign pop_o          = rst && (state_q == ST_IDLE) && !q_empty_i;
  assign clear_val_o    = rst && notif_val_o && notif_rdy_i;

  assign mem_req_fire  = mem_req_val_o && mem_req_rdy_i;
  assign ptr_req_fire  = ptr_req_val_o && ptr_req_rdy_i;
  assign mem_resp_fire = mem_resp_rdy_o && mem_resp_val_i;
  assign ptr_resp_fire = ptr_resp_rdy_o && ptr_resp_val_i;

  assign store_en_o.flowid_en = pop_o;
  assign store_en_o.req_en    = mem_resp_fire;
  assign store_en_o.ptr_en    = ptr_resp_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mem_req_done_q <= 1'b0;
      ptr_req_done_q <= 1'b0;
      mem_held_q     <= 1'b0;
      ptr_held_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!q_empty_i) begin
            state_q        <= ST_RD_REQ;
            mem_req_done_q <= 1'b0;
            ptr_req_done_q <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          if (mem_req_fire) mem_req_done_q <= 1'b1;
          if (ptr_req_fire) ptr_req_done_q <= 1'b1;
          if ((mem_req_done_q || mem_req_fire) && (ptr_req_done_q || ptr_req_fire)) begin
            state_q    <= ST_WAIT_RESP;
            mem_held_q <= 1'b0;
            ptr_held_q <= 1'b0;
          end
        end
        ST_WAIT_RESP: begin
          if (mem_resp_fire) mem_held_q <= 1'b1;
          if (ptr_resp_fire) ptr_held_q <= 1'b1;
          if ((mem_held_q || mem_resp_fire) && (ptr_held_q || ptr_resp_fire))
            state_q <= ST_DECIDE;
        end
        ST_DECIDE:  state_q <= data_ctrl_notify ? ST_NOTIF : ST_REQUEUE;
        ST_NOTIF:   if (notif_rdy_i) state_q <= ST_IDLE;
        ST_REQUEUE: if (q_wr_rdy_i) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/tcp_msg_poller_service.sv
// Service side of the TCP message poller: datapath registers, modulo pointer
// subtraction and length compare, wrapped around the control FSM.
module tcp_msg_poller_service
  import tcp_msg_poller_service_pkg::*;
#(
  parameter int POLLER_PTR_W = MSG_LEN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_req_q_service_empty,
  input  logic [FLOWID_W-1:0]        msg_req_q_service_rd_flowid,
  output logic                       service_msg_req_q_rd_req,
  output logic                       service_msg_req_q_wr_req_val,
  output logic [FLOWID_W-1:0]        service_msg_req_q_wr_req_data,
  input  logic                       msg_req_q_service_wr_req_rdy,
  output logic                       service_msg_req_mem_rd_req_val,
  output logic [FLOWID_W-1:0]        service_msg_req_mem_rd_req_addr,
  input  logic                       msg_req_mem_service_rd_req_rdy,
  input  logic                       msg_req_mem_service_rd_resp_val,
  input  msg_req_mem_struct          msg_req_mem_service_rd_resp_data,
  output logic                       service_msg_req_mem_rd_resp_rdy,
  output logic                       service_rx_ptrs_rd_req_val,
  output logic [FLOWID_W-1:0]        service_rx_ptrs_rd_req_flowid,
  input  logic                       rx_ptrs_service_rd_req_rdy,
  input  logic                       rx_ptrs_service_rd_resp_val,
  input  logic [POLLER_PTR_W-1:0]    rx_ptrs_service_rd_resp_head,
  input  logic [POLLER_PTR_W-1:0]    rx_ptrs_service_rd_resp_commit,
  output logic                       service_rx_ptrs_rd_resp_rdy,
  output logic                       poller_dst_notif_val,
  output logic [FLOWID_W-1:0]        poller_dst_notif_flowid,
  output logic [POLLER_PTR_W-1:0]    poller_dst_notif_len,
  output logic [MSG_SRC_X_WIDTH-1:0] poller_dst_notif_dst_x,
  output logic [MSG_SRC_Y_WIDTH-1:0] poller_dst_notif_dst_y,
  output logic [NOC_FBITS_WIDTH-1:0] poller_dst_notif_dst_fbits,
  input  logic                       dst_poller_notif_rdy,
  output logic                       service_active_bitvec_clear_req_val,
  output logic [FLOWID_W-1:0]        service_active_bitvec_clear_req_flowid
);
  logic [FLOWID_W-1:0]     flowid_q;
  msg_req_mem_struct       req_q;
  logic [POLLER_PTR_W-1:0] head_q, commit_q;
  logic [POLLER_PTR_W-1:0] avail, req_len;
  store_en_t               store_en;
  logic                    data_ctrl_notify;

  tcp_msg_poller_service_ctrl u_ctrl (
    .clk              (clk),
    .rst              (rst),
    .q_empty_i        (msg_req_q_service_empty),
    .q_wr_rdy_i       (msg_req_q_service_wr_req_rdy),
    .mem_req_rdy_i    (msg_req_mem_service_rd_req_rdy),
    .mem_resp_val_i   (msg_req_mem_service_rd_resp_val),
    .ptr_req_rdy_i    (rx_ptrs_service_rd_req_rdy),
    .ptr_resp_val_i   (rx_ptrs_service_rd_resp_val),
    .notif_rdy_i      (dst_poller_notif_rdy),
    .data_ctrl_notify (data_ctrl_notify),
    .pop_o            (service_msg_req_q_rd_req),
    .mem_req_val_o    (service_msg_req_mem_rd_req_val),
    .ptr_req_val_o    (service_rx_ptrs_rd_req_val),
    .mem_resp_rdy_o   (service_msg_req_mem_rd_resp_rdy),
    .ptr_resp_rdy_o   (service_rx_ptrs_rd_resp_rdy),
    .notif_val_o      (poller_dst_notif_val),
    .requeue_val_o    (service_msg_req_q_wr_req_val),
    .clear_val_o      (service_active_bitvec_clear_req_val),
    .store_en_o       (store_en)
  );

  // Data registers are cleared too so every payload output reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flowid_q <= '0;
      req_q    <= '0;
      head_q   <= '0;
      commit_q <= '0;
    end else begin
      if (store_en.flowid_en) flowid_q <= msg_req_q_service_rd_flowid;
      if (store_en.req_en)    req_q    <= msg_req_mem_service_rd_resp_data;
      if (store_en.ptr_en) begin
        head_q   <= rx_ptrs_service_rd_resp_head;
        commit_q <= rx_ptrs_service_rd_resp_commit;
      end
    end
  end

  // Modulo subtraction handles commit having wrapped past head.
  assign avail            = commit_q - head_q;
  assign req_len          = POLLER_PTR_W'(req_q.length);
  assign data_ctrl_notify = (avail >= req_len);

  assign service_msg_req_q_wr_req_data          = flowid_q;
  assign service_msg_req_mem_rd_req_addr        = flowid_q;
  assign service_rx_ptrs_rd_req_flowid          = flowid_q;
  assign poller_dst_notif_flowid                = flowid_q;
  assign poller_dst_notif_len                   = req_len;
  assign poller_dst_notif_dst_x                 = req_q.dst_x;
  assign poller_dst_notif_dst_y                 = req_q.dst_y;
  assign poller_dst_notif_dst_fbits             = req_q.dst_fbits;
  assign service_active_bitvec_clear_req_flowid = flowid_q;
endmodule
